// File: rtl/acc_alu.sv
// acc_alu: accumulator ALU with single-cycle ops and optional iterative multiply (ACC_ALU_MUL_EN)
module acc_alu #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In,
  input  logic [2:0]       OP,
  input  logic             Start,
  output logic             Ready,
  output logic [WIDTH-1:0] Acc,
  output logic             Zero,
  output logic             Carry,
  output logic             Done
);
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   add_w, sub_w;
  assign add_w = {1'b0, acc_q} + {1'b0, In};
  assign sub_w = {1'b0, acc_q} - {1'b0, In};
`ifdef ACC_ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d, psum;
  logic [CW-1:0]      cnt_q, cnt_d;
  assign Ready = state_q == IDLE;
`else
  assign Ready = 1'b1;
`endif
  assign Acc   = acc_q;
  assign Zero  = acc_q == '0;
  assign Carry = carry_q;
  assign Done  = done_q;
  // next state: single-cycle ops on acceptance, one shift-add step per busy cycle
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    done_d  = 1'b0;
`ifdef ACC_ALU_MUL_EN
    state_d  = state_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    psum     = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif
    if (Start && Ready) begin
      done_d = 1'b1;
      case (OP)
        3'b000: begin acc_d = acc_q & In; carry_d = 1'b0; end
        3'b001: begin acc_d = acc_q | In; carry_d = 1'b0; end
        3'b010: begin acc_d = add_w[WIDTH-1:0]; carry_d = add_w[WIDTH]; end
        3'b011: begin acc_d = sub_w[WIDTH-1:0]; carry_d = sub_w[WIDTH]; end
        3'b100: begin acc_d = {{(WIDTH-1){1'b0}}, sub_w[WIDTH]}; carry_d = 1'b0; end
        3'b101: begin acc_d = In; carry_d = 1'b0; end
`ifdef ACC_ALU_MUL_EN
        3'b110: begin
          done_d   = 1'b0;
          state_d  = MUL;
          mplier_d = acc_q;
          mcand_d  = {{WIDTH{1'b0}}, In};
          prod_d   = '0;
          cnt_d    = '0;
        end
`endif
        default: ;
      endcase
    end
`ifdef ACC_ALU_MUL_EN
    if (state_q == MUL) begin
      prod_d   = psum;
      mplier_d = mplier_q >> 1;
      mcand_d  = mcand_q << 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        acc_d   = psum[WIDTH-1:0];
        carry_d = |psum[2*WIDTH-1:WIDTH];
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
`endif
  end
  // state registers; reset aborts any in-flight multiply
  always_ff @(posedge CLK) begin
    if (Reset) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef ACC_ALU_MUL_EN
      state_q <= IDLE;
`endif
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      done_q  <= done_d;
`ifdef ACC_ALU_MUL_EN
      state_q  <= state_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_acc_alu.sv
// tb_acc_alu: directed scenarios plus randomized traffic against a behavioural accumulator model
module tb_acc_alu;
  localparam int W = 16;
`ifdef ACC_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic         CLK = 1'b0;
  logic         Reset, Start, Ready, Zero, Carry, Done;
  logic [W-1:0] In, Acc;
  logic [2:0]   OP;
  int checks = 0, failures = 0, dones = 0, rdy_low = 0;
  logic [W-1:0] m_acc = '0, m_mop = '0;
  logic         m_carry = 1'b0, m_done = 1'b0;
  int           m_busy = 0;
  acc_alu #(.WIDTH(W)) dut (
    .CLK(CLK), .Reset(Reset), .In(In), .OP(OP), .Start(Start),
    .Ready(Ready), .Acc(Acc), .Zero(Zero), .Carry(Carry), .Done(Done)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step_model(input bit r, input bit s, input logic [2:0] o, input logic [W-1:0] i);
    longint unsigned v;
    m_done = 1'b0;
    if (r) begin
      m_acc = '0; m_carry = 1'b0; m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        v = longint'(m_acc) * longint'(m_mop);
        m_acc = W'(v);
        m_carry = (v >> W) != 0;
        m_done = 1'b1;
      end
    end else if (s) begin
      m_done = 1'b1;
      case (o)
        3'd0: begin m_acc = m_acc & i; m_carry = 1'b0; end
        3'd1: begin m_acc = m_acc | i; m_carry = 1'b0; end
        3'd2: begin v = longint'(m_acc) + longint'(i); m_acc = W'(v); m_carry = (v >> W) != 0; end
        3'd3: begin m_carry = m_acc < i; m_acc = m_acc - i; end
        3'd4: begin m_acc = (m_acc < i) ? W'(1) : W'(0); m_carry = 1'b0; end
        3'd5: begin m_acc = i; m_carry = 1'b0; end
        3'd6: if (MUL_EN) begin m_busy = W; m_mop = i; m_done = 1'b0; end
        default: ;
      endcase
    end
  endtask
  task automatic cyc(input bit r, input bit s, input logic [2:0] o, input logic [W-1:0] i);
    Reset = r; Start = s; OP = o; In = i;
    @(posedge CLK);
    step_model(r, s, o, i);
    @(negedge CLK);
    check("acc", Acc, m_acc);
    check("zero", Zero, m_acc == 0);
    check("carry", Carry, m_carry);
    check("ready", Ready, m_busy == 0);
    check("done", Done, m_done);
    if (Done) dones++;
    if (!Ready) rdy_low++;
  endtask
  initial begin
    Reset = 1'b1; Start = 1'b0; OP = '0; In = '0;
    @(negedge CLK);
    cyc(1, 1, 3'd5, 16'h1234);
    check("rst_acc", Acc, 0);
    check("rst_zero", Zero, 1);
    check("rst_ready", Ready, 1);
    check("rst_done", Done, 0);
    dones = 0; rdy_low = 0;
    cyc(0, 1, 3'd5, 16'h0005);
    cyc(0, 1, 3'd0, 16'h0001);
    check("and_acc", Acc, 16'h0001);
    check("and_zero", Zero, 0);
    check("and_carry", Carry, 0);
    check("and_dones", dones, 2);
    check("and_ready", rdy_low, 0);
    cyc(0, 1, 3'd5, 16'hFFFF);
    cyc(0, 1, 3'd2, 16'h0001);
    check("add_acc", Acc, 16'h0000);
    check("add_carry", Carry, 1);
    check("add_zero", Zero, 1);
    cyc(0, 1, 3'd5, 16'h0001);
    cyc(0, 1, 3'd3, 16'h0005);
    check("sub_acc", Acc, 16'hFFFC);
    check("sub_carry", Carry, 1);
    cyc(0, 1, 3'd4, 16'hFFFD);
    check("slt_acc", Acc, 16'h0001);
    check("slt_carry", Carry, 0);
`ifdef ACC_ALU_MUL_EN
    cyc(0, 1, 3'd5, 16'd3);
    dones = 0; rdy_low = 0;
    cyc(0, 1, 3'd6, 16'd7);
    repeat (16) cyc(0, 1, 3'd2, 16'd1);
    check("mul_acc", Acc, 16'd21);
    check("mul_carry", Carry, 0);
    check("mul_dones", dones, 1);
    check("mul_busy", rdy_low, 16);
    cyc(0, 0, 3'd0, 16'd0);
    cyc(0, 1, 3'd5, 16'h0100);
    dones = 0;
    cyc(0, 1, 3'd6, 16'h0100);
    repeat (4) cyc(0, 0, 3'd0, 16'd0);
    cyc(1, 0, 3'd0, 16'd0);
    check("abort_acc", Acc, 0);
    check("abort_ready", Ready, 1);
    repeat (20) cyc(0, 0, 3'd0, 16'd0);
    check("abort_dones", dones, 0);
`else
    cyc(0, 1, 3'd5, 16'hFFFF);
    cyc(0, 1, 3'd2, 16'd10);
    dones = 0;
    cyc(0, 1, 3'd6, 16'd2);
    check("nomul_acc", Acc, 16'd9);
    check("nomul_carry", Carry, 1);
    check("nomul_done", Done, 1);
    check("nomul_ready", Ready, 1);
    cyc(0, 0, 3'd0, 16'd0);
    check("nomul_dones", dones, 1);
`endif
    cyc(0, 1, 3'd7, 16'hABCD);
    for (int n = 0; n < 1500; n++) begin
      int k;
      logic [W-1:0] v;
      k = $urandom_range(0, 3);
      v = (k == 0) ? W'($urandom_range(0, 3)) : (k == 1) ? ~W'($urandom_range(0, 3)) : W'($urandom);
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), v);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
